// File: rtl/wfifo_width_conv.sv
// Single-clock FIFO with width conversion: wide words are written, narrow lanes
// are read back in a selectable lane order. It reports occupancy in both word
// units and keeps sticky overflow/underflow flags.
module wfifo_width_conv #(
    parameter int unsigned WR_DATA_WIDTH    = 64,
    parameter int unsigned RD_DATA_WIDTH    = 16,
    parameter int unsigned WR_DEPTH_WIDTH   = 8,
    parameter int unsigned OUTPUT_REG       = 0,
    parameter int unsigned MSB_FIRST        = 1,
    parameter int unsigned ALMOST_FULL_NUM  = 252,
    parameter int unsigned ALMOST_EMPTY_NUM = 4,
    localparam int unsigned RATIO          = WR_DATA_WIDTH / RD_DATA_WIDTH,
    localparam int unsigned LOG2_RATIO     = $clog2(RATIO),
    localparam int unsigned RD_DEPTH_WIDTH = WR_DEPTH_WIDTH + LOG2_RATIO
) (
    input  logic                      clk,
    input  logic                      tb_rst,
    input  logic                      wr_en,
    input  logic [WR_DATA_WIDTH-1:0]  wr_data,
    output logic                      wr_full,
    output logic                      almost_full,
    output logic [WR_DEPTH_WIDTH:0]   wr_water_level,
    input  logic                      rd_en,
    output logic [RD_DATA_WIDTH-1:0]  rd_data,
    output logic                      rd_valid,
    output logic                      rd_empty,
    output logic                      almost_empty,
    output logic [RD_DEPTH_WIDTH:0]   rd_water_level,
    output logic                      overflow,
    output logic                      underflow,
    input  logic                      clr_err
);

    localparam int unsigned DEPTH  = 1 << WR_DEPTH_WIDTH;
    localparam int unsigned LANE_W = (LOG2_RATIO > 0) ? LOG2_RATIO : 1;

    logic [WR_DEPTH_WIDTH:0]   wr_ptr_reg;
    logic [RD_DEPTH_WIDTH:0]   rd_ptr_reg;
    logic [WR_DATA_WIDTH-1:0]  mem [DEPTH];
    logic [WR_DATA_WIDTH-1:0]  ram_q_reg;
    logic [LANE_W-1:0]         lane_reg;
    logic                      s1_valid_reg;
    logic                      overflow_reg;
    logic                      underflow_reg;
    logic [WR_DEPTH_WIDTH-1:0] rd_addr;
    logic [LANE_W-1:0]         rd_lane;
    logic                      wr_accept;
    logic                      rd_accept;
    logic [RD_DATA_WIDTH-1:0]  lane_word [RATIO];
    logic [RD_DATA_WIDTH-1:0]  lane_data;

    // Levels come straight from the registered pointers; a partly read wide
    // word still occupies its slot until its last lane is consumed.
    assign wr_water_level = wr_ptr_reg - rd_ptr_reg[RD_DEPTH_WIDTH:LOG2_RATIO];
    assign rd_water_level = ((RD_DEPTH_WIDTH+1)'(wr_ptr_reg) << LOG2_RATIO) - rd_ptr_reg;

    assign wr_full      = (wr_water_level == (WR_DEPTH_WIDTH+1)'(DEPTH));
    assign rd_empty     = (rd_water_level == '0);
    assign almost_full  = (32'(wr_water_level) >= ALMOST_FULL_NUM);
    assign almost_empty = (32'(rd_water_level) <= ALMOST_EMPTY_NUM);

    assign wr_accept = wr_en & ~wr_full;
    assign rd_accept = rd_en & ~rd_empty;
    assign rd_addr   = rd_ptr_reg[RD_DEPTH_WIDTH-1:LOG2_RATIO];

    generate
        if (LOG2_RATIO > 0) begin : g_lane_idx
            assign rd_lane = rd_ptr_reg[LANE_W-1:0];
        end else begin : g_lane_none
            assign rd_lane = '0;
        end
    endgenerate

    // Lane slicing of the RAM output word; lane 0 is the first one read.
    genvar gi;
    generate
        for (gi = 0; gi < RATIO; gi++) begin : g_lanes
            if (MSB_FIRST != 0) begin : g_msb
                assign lane_word[gi] = ram_q_reg[WR_DATA_WIDTH-1-gi*RD_DATA_WIDTH -: RD_DATA_WIDTH];
            end else begin : g_lsb
                assign lane_word[gi] = ram_q_reg[gi*RD_DATA_WIDTH +: RD_DATA_WIDTH];
            end
        end
    endgenerate

    assign lane_data = lane_word[lane_reg];

    // Pointer advance on accepted operations; rejected requests leave them alone.
    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (wr_accept) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (rd_accept) rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    // Storage write port; contents are never reset, the pointers define validity.
    always_ff @(posedge clk) begin
        if (wr_accept) mem[wr_ptr_reg[WR_DEPTH_WIDTH-1:0]] <= wr_data;
    end

    // Synchronous RAM read plus the lane index travelling alongside it.
    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            ram_q_reg    <= '0;
            lane_reg     <= '0;
            s1_valid_reg <= 1'b0;
        end else begin
            s1_valid_reg <= rd_accept;
            if (rd_accept) begin
                ram_q_reg <= mem[rd_addr];
                lane_reg  <= rd_lane;
            end
        end
    end

    // Sticky error flags; a new error in the same cycle as clr_err wins.
    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (wr_en && wr_full)  overflow_reg <= 1'b1;
            else if (clr_err)      overflow_reg <= 1'b0;
            if (rd_en && rd_empty) underflow_reg <= 1'b1;
            else if (clr_err)      underflow_reg <= 1'b0;
        end
    end

    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;

    generate
        if (OUTPUT_REG != 0) begin : g_out_reg
            logic [RD_DATA_WIDTH-1:0] rd_data_reg;
            logic                     rd_valid_reg;

            // Extra pipeline stage after the lane mux for timing closure.
            always_ff @(posedge clk or posedge tb_rst) begin
                if (tb_rst) begin
                    rd_data_reg  <= '0;
                    rd_valid_reg <= 1'b0;
                end else begin
                    rd_valid_reg <= s1_valid_reg;
                    if (s1_valid_reg) rd_data_reg <= lane_data;
                end
            end

            assign rd_data  = rd_data_reg;
            assign rd_valid = rd_valid_reg;
        end else begin : g_out_direct
            assign rd_data  = lane_data;
            assign rd_valid = s1_valid_reg;
        end
    endgenerate

endmodule

// File: tb/tb_wfifo_width_conv.sv
// Bench for wfifo_width_conv: instance A uses the defaults (MSB first,
// 1-cycle latency), instance B reads LSB first with the output register.
// Both share stimulus and are compared against a queue-based model.
`timescale 1ns/1ps
module tb_wfifo_width_conv;

    logic        clk = 1'b0;
    logic        tb_rst = 1'b1;
    logic        wr_en = 1'b0, rd_en = 1'b0, clr_err = 1'b0;
    logic [63:0] wr_data = '0;

    logic        wr_full_a, almost_full_a, rd_valid_a, rd_empty_a, almost_empty_a, overflow_a, underflow_a;
    logic [8:0]  wr_water_level_a;
    logic [10:0] rd_water_level_a;
    logic [15:0] rd_data_a;
    logic        wr_full_b, almost_full_b, rd_valid_b, rd_empty_b, almost_empty_b, overflow_b, underflow_b;
    logic [8:0]  wr_water_level_b;
    logic [10:0] rd_water_level_b;
    logic [15:0] rd_data_b;

    always #5 clk = ~clk;

    wfifo_width_conv u_dut_a (
        .clk(clk), .tb_rst(tb_rst), .wr_en(wr_en), .wr_data(wr_data),
        .wr_full(wr_full_a), .almost_full(almost_full_a), .wr_water_level(wr_water_level_a),
        .rd_en(rd_en), .rd_data(rd_data_a), .rd_valid(rd_valid_a), .rd_empty(rd_empty_a),
        .almost_empty(almost_empty_a), .rd_water_level(rd_water_level_a),
        .overflow(overflow_a), .underflow(underflow_a), .clr_err(clr_err)
    );

    wfifo_width_conv #(.OUTPUT_REG(1), .MSB_FIRST(0)) u_dut_b (
        .clk(clk), .tb_rst(tb_rst), .wr_en(wr_en), .wr_data(wr_data),
        .wr_full(wr_full_b), .almost_full(almost_full_b), .wr_water_level(wr_water_level_b),
        .rd_en(rd_en), .rd_data(rd_data_b), .rd_valid(rd_valid_b), .rd_empty(rd_empty_b),
        .almost_empty(almost_empty_b), .rd_water_level(rd_water_level_b),
        .overflow(overflow_b), .underflow(underflow_b), .clr_err(clr_err)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: narrow words pending in each lane order.
    logic [15:0] q_msb[$];
    logic [15:0] q_lsb[$];
    logic        exp_v_a, exp_v_b, pipe_v, m_ovf, m_unf;
    logic [15:0] exp_d_a, exp_d_b, pipe_d;
    bit          verbose = 0;

    function automatic int m_rl();
        return q_msb.size();
    endfunction

    function automatic int m_wl();
        return (q_msb.size() + 3) / 4;
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    task automatic model_reset();
        q_msb.delete();
        q_lsb.delete();
        exp_v_a = 0; exp_v_b = 0; pipe_v = 0;
        exp_d_a = '0; exp_d_b = '0; pipe_d = '0;
        m_ovf = 0; m_unf = 0;
    endtask

    // Drive one cycle of stimulus and advance the model; returns 1 ns after the edge.
    task automatic step(input logic w, input logic [63:0] d, input logic r, input logic c);
        bit full, empty, wa, ra;
        full  = (m_wl() == 256);
        empty = (q_msb.size() == 0);
        wa = w && !full;
        ra = r && !empty;
        wr_en = w; wr_data = d; rd_en = r; clr_err = c;
        @(posedge clk);
        if (w && full) m_ovf = 1; else if (c) m_ovf = 0;
        if (r && empty) m_unf = 1; else if (c) m_unf = 0;
        exp_v_b = pipe_v;
        if (pipe_v) exp_d_b = pipe_d;
        pipe_v  = ra;
        exp_v_a = ra;
        if (ra) begin
            exp_d_a = q_msb.pop_front();
            pipe_d  = q_lsb.pop_front();
        end
        if (wa) begin
            for (int k = 0; k < 4; k++) begin
                q_msb.push_back(d[63-16*k -: 16]);
                q_lsb.push_back(d[16*k +: 16]);
            end
        end
        if (verbose)
            $display("txn t=%0t wr=%0b acc=%0b data=%h rd=%0b acc=%0b level=%0d", $time, w, wa, d, r, ra, q_msb.size());
        #1;
        wr_en = 0; rd_en = 0; clr_err = 0;
    endtask

    task automatic test_reset(input string tag);
        checks++; if (rd_data_a !== 16'h0) begin failures++; $display("FAIL %s_rd_data_a actual=%h expected=0000", tag, rd_data_a); end
        checks++; if (rd_valid_a !== 1'b0) begin failures++; $display("FAIL %s_rd_valid_a actual=%b expected=0", tag, rd_valid_a); end
        checks++; if (rd_empty_a !== 1'b1) begin failures++; $display("FAIL %s_rd_empty_a actual=%b expected=1", tag, rd_empty_a); end
        checks++; if (almost_empty_a !== 1'b1) begin failures++; $display("FAIL %s_almost_empty_a actual=%b expected=1", tag, almost_empty_a); end
        checks++; if (wr_full_a !== 1'b0) begin failures++; $display("FAIL %s_wr_full_a actual=%b expected=0", tag, wr_full_a); end
        checks++; if (almost_full_a !== 1'b0) begin failures++; $display("FAIL %s_almost_full_a actual=%b expected=0", tag, almost_full_a); end
        checks++; if (wr_water_level_a !== 9'd0) begin failures++; $display("FAIL %s_wr_level_a actual=%0d expected=0", tag, wr_water_level_a); end
        checks++; if (rd_water_level_a !== 11'd0) begin failures++; $display("FAIL %s_rd_level_a actual=%0d expected=0", tag, rd_water_level_a); end
        checks++; if (overflow_a !== 1'b0 || underflow_a !== 1'b0) begin failures++; $display("FAIL %s_err_flags_a actual=%b%b expected=00", tag, overflow_a, underflow_a); end
        checks++; if (rd_data_b !== 16'h0 || rd_valid_b !== 1'b0) begin failures++; $display("FAIL %s_rd_b actual=%h/%b expected=0000/0", tag, rd_data_b, rd_valid_b); end
        checks++; if (rd_water_level_b !== 11'd0 || rd_empty_b !== 1'b1) begin failures++; $display("FAIL %s_level_b actual=%0d/%b expected=0/1", tag, rd_water_level_b, rd_empty_b); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 256; i++) begin
            step(1, 64'hFFFF_FFFF_FFFF_FFFF - 64'(i), 0, 0);
            checks++; if (wr_water_level_a !== 9'(i + 1)) begin failures++; $display("FAIL fill_wr_level actual=%0d expected=%0d", wr_water_level_a, i + 1); end
            checks++; if (almost_full_a !== (i + 1 >= 252)) begin failures++; $display("FAIL fill_almost_full n=%0d actual=%b expected=%b", i + 1, almost_full_a, (i + 1 >= 252)); end
            checks++; if (wr_full_a !== (i + 1 == 256)) begin failures++; $display("FAIL fill_wr_full n=%0d actual=%b expected=%b", i + 1, wr_full_a, (i + 1 == 256)); end
        end
        checks++; if (rd_water_level_a !== 11'd1024) begin failures++; $display("FAIL fill_rd_level actual=%0d expected=1024", rd_water_level_a); end
        step(1, 64'h1234, 0, 0);
        checks++; if (overflow_a !== 1'b1 || overflow_b !== 1'b1) begin failures++; $display("FAIL fill_overflow actual=%b/%b expected=1/1", overflow_a, overflow_b); end
        checks++; if (wr_water_level_a !== 9'd256 || rd_water_level_a !== 11'd1024) begin failures++; $display("FAIL fill_levels_held actual=%0d/%0d expected=256/1024", wr_water_level_a, rd_water_level_a); end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 1024; i++) begin
            step(0, '0, 1, 0);
            checks++; if (rd_valid_a !== 1'b1 || rd_data_a !== exp_d_a) begin failures++; $display("FAIL drain_a i=%0d actual=%h/%b expected=%h/1", i, rd_data_a, rd_valid_a, exp_d_a); end
            checks++; if (rd_valid_b !== exp_v_b || rd_data_b !== exp_d_b) begin failures++; $display("FAIL drain_b i=%0d actual=%h/%b expected=%h/%b", i, rd_data_b, rd_valid_b, exp_d_b, exp_v_b); end
            checks++; if (rd_water_level_a !== 11'(1023 - i)) begin failures++; $display("FAIL drain_rd_level actual=%0d expected=%0d", rd_water_level_a, 1023 - i); end
        end
        checks++; if (rd_data_a !== 16'hFF00) begin failures++; $display("FAIL drain_last_word actual=%h expected=ff00", rd_data_a); end
        checks++; if (rd_empty_a !== 1'b1 || wr_water_level_a !== 9'd0) begin failures++; $display("FAIL drain_empty actual=%b/%0d expected=1/0", rd_empty_a, wr_water_level_a); end
        step(0, '0, 1, 0);
        checks++; if (underflow_a !== 1'b1 || rd_valid_a !== 1'b0) begin failures++; $display("FAIL drain_underflow actual=%b valid=%b expected=1 valid=0", underflow_a, rd_valid_a); end
        checks++; if (rd_valid_b !== 1'b1 || rd_data_b !== exp_d_b) begin failures++; $display("FAIL drain_b_tail actual=%h/%b expected=%h/1", rd_data_b, rd_valid_b, exp_d_b); end
        step(0, '0, 0, 0);
        checks++; if (rd_valid_b !== 1'b0 || underflow_b !== 1'b1) begin failures++; $display("FAIL drain_b_idle actual=%b/%b expected=0/1", rd_valid_b, underflow_b); end
    endtask

    task automatic test_single();
        logic [15:0] msb [4];
        logic [15:0] lsb [4];
        msb = '{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF};
        lsb = '{16'hCDEF, 16'h89AB, 16'h4567, 16'h0123};
        verbose = 1;
        step(0, '0, 0, 1);
        checks++; if (overflow_a !== 1'b0 || underflow_a !== 1'b0) begin failures++; $display("FAIL single_clr actual=%b%b expected=00", overflow_a, underflow_a); end
        step(1, 64'h0123_4567_89AB_CDEF, 0, 0);
        checks++; if (rd_water_level_a !== 11'd4 || wr_water_level_a !== 9'd1) begin failures++; $display("FAIL single_levels actual=%0d/%0d expected=4/1", rd_water_level_a, wr_water_level_a); end
        for (int k = 0; k < 4; k++) begin
            step(0, '0, 1, 0);
            checks++; if (rd_data_a !== msb[k]) begin failures++; $display("FAIL single_data_a k=%0d actual=%h expected=%h", k, rd_data_a, msb[k]); end
            checks++; if (rd_water_level_a !== 11'(3 - k) || wr_water_level_a !== 9'((k == 3) ? 0 : 1)) begin failures++; $display("FAIL single_levels k=%0d actual=%0d/%0d expected=%0d/%0d", k, rd_water_level_a, wr_water_level_a, 3 - k, (k == 3) ? 0 : 1); end
            if (k > 0) begin
                checks++; if (rd_data_b !== lsb[k-1]) begin failures++; $display("FAIL single_data_b k=%0d actual=%h expected=%h", k - 1, rd_data_b, lsb[k-1]); end
            end
        end
        step(0, '0, 0, 0);
        checks++; if (rd_data_b !== lsb[3] || rd_valid_b !== 1'b1) begin failures++; $display("FAIL single_data_b_last actual=%h/%b expected=%h/1", rd_data_b, rd_valid_b, lsb[3]); end
        checks++; if (rd_valid_a !== 1'b0 || rd_data_a !== msb[3]) begin failures++; $display("FAIL single_hold_a actual=%h/%b expected=%h/0", rd_data_a, rd_valid_a, msb[3]); end
        verbose = 0;
    endtask

    task automatic test_latency();
        step(1, rand64(), 0, 0);
        step(1, rand64(), 0, 0);
        step(0, '0, 1, 0);
        checks++; if (rd_valid_b !== 1'b0 || rd_valid_a !== 1'b1) begin failures++; $display("FAIL lat_n1 actual=b%b/a%b expected=b0/a1", rd_valid_b, rd_valid_a); end
        step(0, '0, 0, 0);
        checks++; if (rd_valid_b !== 1'b1 || rd_data_b !== exp_d_b) begin failures++; $display("FAIL lat_n2 actual=%h/%b expected=%h/1", rd_data_b, rd_valid_b, exp_d_b); end
        for (int k = 0; k < 7; k++) begin
            step(0, '0, 1, 0);
            if (k >= 1) begin
                checks++; if (rd_valid_b !== 1'b1 || rd_data_b !== exp_d_b) begin failures++; $display("FAIL lat_stream k=%0d actual=%h/%b expected=%h/1", k, rd_data_b, rd_valid_b, exp_d_b); end
            end
        end
        step(0, '0, 0, 0);
        checks++; if (rd_valid_b !== 1'b1 || rd_data_b !== exp_d_b) begin failures++; $display("FAIL lat_tail actual=%h/%b expected=%h/1", rd_data_b, rd_valid_b, exp_d_b); end
        step(0, '0, 0, 0);
        checks++; if (rd_valid_b !== 1'b0) begin failures++; $display("FAIL lat_idle actual=%b expected=0", rd_valid_b); end
    endtask

    task automatic test_simultaneous();
        int prev;
        for (int i = 0; i < 300 && m_wl() < 256; i++) step(1, rand64(), 0, 0);
        checks++; if (wr_full_a !== 1'b1) begin failures++; $display("FAIL simul_full actual=%b expected=1", wr_full_a); end
        step(0, '0, 0, 1);
        prev = m_rl();
        step(1, rand64(), 1, 0);
        checks++; if (overflow_a !== 1'b1) begin failures++; $display("FAIL simul_overflow actual=%b expected=1", overflow_a); end
        checks++; if (rd_water_level_a !== 11'(prev - 1)) begin failures++; $display("FAIL simul_full_rd_level actual=%0d expected=%0d", rd_water_level_a, prev - 1); end
        checks++; if (wr_water_level_a !== 9'(m_wl()) || rd_valid_a !== 1'b1 || rd_data_a !== exp_d_a) begin failures++; $display("FAIL simul_full_read actual=%0d/%h/%b expected=%0d/%h/1", wr_water_level_a, rd_data_a, rd_valid_a, m_wl(), exp_d_a); end
        for (int i = 0; i < 1100 && m_rl() > 0; i++) begin
            step(0, '0, 1, 0);
            checks++; if (rd_data_a !== exp_d_a || rd_data_b !== exp_d_b) begin failures++; $display("FAIL simul_drain actual=%h/%h expected=%h/%h", rd_data_a, rd_data_b, exp_d_a, exp_d_b); end
        end
        step(0, '0, 0, 1);
        step(1, rand64(), 1, 0);
        checks++; if (underflow_a !== 1'b1 || rd_valid_a !== 1'b0) begin failures++; $display("FAIL simul_underflow actual=%b valid=%b expected=1 valid=0", underflow_a, rd_valid_a); end
        checks++; if (rd_water_level_a !== 11'd4 || wr_water_level_a !== 9'd1) begin failures++; $display("FAIL simul_empty_levels actual=%0d/%0d expected=4/1", rd_water_level_a, wr_water_level_a); end
    endtask

    task automatic test_random();
        int pw, pr;
        for (int n = 0; n < 3000; n++) begin
            pw = (n < 1500) ? 70 : 5;
            pr = (n < 1500) ? 30 : 95;
            step($urandom_range(99) < pw, rand64(), $urandom_range(99) < pr, $urandom_range(99) < 2);
            checks++; if (rd_valid_a !== exp_v_a || rd_data_a !== exp_d_a) begin failures++; $display("FAIL rand_rd_a n=%0d actual=%h/%b expected=%h/%b", n, rd_data_a, rd_valid_a, exp_d_a, exp_v_a); end
            checks++; if (rd_valid_b !== exp_v_b || rd_data_b !== exp_d_b) begin failures++; $display("FAIL rand_rd_b n=%0d actual=%h/%b expected=%h/%b", n, rd_data_b, rd_valid_b, exp_d_b, exp_v_b); end
            checks++; if (wr_water_level_a !== 9'(m_wl()) || rd_water_level_a !== 11'(m_rl())) begin failures++; $display("FAIL rand_levels_a n=%0d actual=%0d/%0d expected=%0d/%0d", n, wr_water_level_a, rd_water_level_a, m_wl(), m_rl()); end
            checks++; if (wr_water_level_b !== 9'(m_wl()) || rd_water_level_b !== 11'(m_rl())) begin failures++; $display("FAIL rand_levels_b n=%0d actual=%0d/%0d expected=%0d/%0d", n, wr_water_level_b, rd_water_level_b, m_wl(), m_rl()); end
            checks++; if (wr_full_a !== (m_wl() == 256) || rd_empty_a !== (m_rl() == 0)) begin failures++; $display("FAIL rand_full_empty n=%0d actual=%b/%b expected=%b/%b", n, wr_full_a, rd_empty_a, (m_wl() == 256), (m_rl() == 0)); end
            checks++; if (almost_full_a !== (m_wl() >= 252) || almost_empty_a !== (m_rl() <= 4)) begin failures++; $display("FAIL rand_almost n=%0d actual=%b/%b expected=%b/%b", n, almost_full_a, almost_empty_a, (m_wl() >= 252), (m_rl() <= 4)); end
            checks++; if (overflow_a !== m_ovf || underflow_a !== m_unf) begin failures++; $display("FAIL rand_err n=%0d actual=%b%b expected=%b%b", n, overflow_a, underflow_a, m_ovf, m_unf); end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 1100 && m_rl() > 0; i++) step(0, '0, 1, 0);
        step(0, '0, 0, 0);
        step(0, '0, 0, 0);
        for (int i = 0; i < 125; i++) step(1, rand64(), 0, 0);
        checks++; if (rd_water_level_a !== 11'd500) begin failures++; $display("FAIL mid_level actual=%0d expected=500", rd_water_level_a); end
        step(0, '0, 1, 0);
        #2;
        tb_rst = 1'b1;
        #1;
        model_reset();
        test_reset("mid_async");
        @(posedge clk);
        #1;
        test_reset("mid_held");
        tb_rst = 1'b0;
        verbose = 1;
        step(1, 64'hAAAA_5555_AAAA_5555, 0, 0);
        step(0, '0, 1, 0);
        checks++; if (rd_data_a !== 16'hAAAA) begin failures++; $display("FAIL post_rst_first actual=%h expected=aaaa", rd_data_a); end
        step(0, '0, 1, 0);
        checks++; if (rd_data_a !== 16'h5555 || rd_data_b !== 16'h5555) begin failures++; $display("FAIL post_rst_second actual=%h/%h expected=5555/5555", rd_data_a, rd_data_b); end
        step(0, '0, 1, 0);
        step(0, '0, 1, 0);
        step(0, '0, 1, 0);
        checks++; if (underflow_a !== 1'b1) begin failures++; $display("FAIL clr_setup actual=%b expected=1", underflow_a); end
        step(0, '0, 1, 1);
        checks++; if (underflow_a !== 1'b1) begin failures++; $display("FAIL clr_set_wins actual=%b expected=1", underflow_a); end
        step(0, '0, 0, 1);
        checks++; if (underflow_a !== 1'b0 || overflow_a !== 1'b0) begin failures++; $display("FAIL clr_err actual=%b%b expected=00", overflow_a, underflow_a); end
        verbose = 0;
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        test_reset("init");
        tb_rst = 1'b0;
        test_fill();
        test_drain();
        test_single();
        test_latency();
        test_simultaneous();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/wfifo_width_conv.md
Name: wfifo_width_conv

Overview:
Single-clock FIFO with width conversion. Accepts wide words (e.g. 64-bit DDR3 read bursts) and returns narrow words (e.g. 16-bit HDMI pixels). Generalises the fixed 64->16 FIFO in three ways:
- width ratio, depth and thresholds are parameters;
- lane order and an optional output register are selectable;
- water levels are reported in both word units, and sticky overflow/underflow flags are added.

Sits between the DDR3 read arbiter and the video timing/pixel path.

Parameters:
- WR_DATA_WIDTH, 64, write word width; must equal RD_DATA_WIDTH*RATIO, where RATIO is a power of 2 and 1..16.
- RD_DATA_WIDTH, 16, read word width.
- WR_DEPTH_WIDTH, 8, log2 of storage depth in wide words. RD_DEPTH_WIDTH = WR_DEPTH_WIDTH + log2(RATIO) (derived localparam).
- OUTPUT_REG, 0, 1 = extra output register stage (read latency 2).
- MSB_FIRST, 1, 1 = most-significant lane of a wide word is read first; 0 = least-significant lane first.
- ALMOST_FULL_NUM, 252, almost_full threshold in wide words.
- ALMOST_EMPTY_NUM, 4, almost_empty threshold in narrow words.

Ports:
- clk, in, 1, clock for both sides.
- tb_rst, in, 1, reset; asynchronous, active-high.
- wr_en, in, 1, write request.
- wr_data, in, WR_DATA_WIDTH, write word.
- wr_full, out, 1, no wide slot free.
- almost_full, out, 1, wr_water_level >= ALMOST_FULL_NUM.
- wr_water_level, out, WR_DEPTH_WIDTH+1, occupied wide slots.
- rd_en, in, 1, read request.
- rd_data, out, RD_DATA_WIDTH, read word.
- rd_valid, out, 1, rd_data updated this cycle.
- rd_empty, out, 1, no narrow word available.
- almost_empty, out, 1, rd_water_level <= ALMOST_EMPTY_NUM.
- rd_water_level, out, RD_DEPTH_WIDTH+1, available narrow words.
- overflow, out, 1, sticky: write attempted while full.
- underflow, out, 1, sticky: read attempted while empty.
- clr_err, in, 1, synchronous clear of overflow/underflow.

Behaviour:
- Reset (tb_rst high, async):
  - pointers = 0, rd_data = 0, rd_valid = 0;
  - rd_empty = 1, almost_empty = 1, wr_full = 0, almost_full = 0;
  - both levels = 0, overflow = underflow = 0.
  - Reset asserted mid-operation discards all contents immediately. No output glitches to non-reset values while tb_rst is high.
- Pointers:
  - wr_ptr: WR_DEPTH_WIDTH+1 bits, counts wide words.
  - rd_ptr: RD_DEPTH_WIDTH+1 bits, counts narrow words.
  - Both wrap naturally modulo 2^(width).
- Level arithmetic (modulo pointer width):
  - rd_water_level = (wr_ptr << log2 RATIO) - rd_ptr.
  - wr_water_level = wr_ptr - (rd_ptr >> log2 RATIO). A partially consumed wide word still counts as occupied.
- Flags:
  - wr_full = (wr_water_level == 2^WR_DEPTH_WIDTH); rd_empty = (rd_water_level == 0).
  - All flags and levels derive from registered pointers, so they reflect an accepted operation on the next cycle.
- Write:
  - Accepted when wr_en && !wr_full; stores wr_data at wr_ptr[WR_DEPTH_WIDTH-1:0], then wr_ptr+1.
  - wr_en while full: data dropped, pointer held, overflow <= 1.
- Read:
  - Accepted when rd_en && !rd_empty; lane index L = rd_ptr[log2 RATIO-1:0], then rd_ptr+1.
  - MSB_FIRST=1 selects bits [WR_DATA_WIDTH-1-L*RD_DATA_WIDTH -: RD_DATA_WIDTH].
  - MSB_FIRST=0 selects bits [L*RD_DATA_WIDTH +: RD_DATA_WIDTH].
  - rd_en while empty: no pointer change, underflow <= 1.
- Latency:
  - OUTPUT_REG=0: rd_data and rd_valid change on the clock edge following the accepted rd_en (1 cycle).
  - OUTPUT_REG=1: 2 cycles.
  - rd_valid is a 1-cycle pulse per accepted read. rd_data holds its last value otherwise.
- Simultaneous events:
  - Write while full plus read in the same cycle: the write is rejected, because full is evaluated on current state.
  - Read while empty plus write in the same cycle: the read is rejected (underflow set); the write is accepted.
  - When both are accepted, both levels update consistently: wr_water_level changes by +1, or by 0 when the read completes a wide word's last lane.
  - clr_err and an error event in the same cycle: the flag is set (set wins).
- Storage: inferred RAM of 2^WR_DEPTH_WIDTH x WR_DATA_WIDTH with a synchronous read; lane mux after the RAM.

Test Plan:
1. Default parameters; write 256 words counting down from 0xFFFF_FFFF_FFFF_FFFF -> wr_full=1 the cycle after the 256th accept, wr_water_level=256, rd_water_level=1024, almost_full first asserts after the 252nd write. A 257th write -> overflow=1 and levels unchanged.
2. Read 1024 words back -> 0xFFFF,0xFFFF,0xFFFF,0xFFFF then 0xFFFF,0xFFFF,0xFFFF,0xFFFE, ..., last four 0xFFFF,0xFFFF,0xFFFF,0xFF00. rd_empty=1 after the 1024th; a 1025th rd_en -> underflow=1, rd_valid stays 0.
3. One write 0x0123_4567_89AB_CDEF, then single reads -> rd_water_level 4,3,2,1,0 and wr_water_level 1,1,1,1,0. Data is 0x0123,0x4567,0x89AB,0xCDEF; with MSB_FIRST=0 it is 0xCDEF,0x89AB,0x4567,0x0123.
4. OUTPUT_REG=1: rd_en pulse at cycle N -> rd_valid and data at N+2; back-to-back reads stream one word per cycle with no bubbles.
5. Full FIFO: assert wr_en and rd_en together -> read accepted, write rejected, overflow=1. Empty FIFO: assert wr_en and rd_en together -> write accepted, underflow=1, rd_water_level=4 next cycle.
6. Assert tb_rst asynchronously mid-stream (level 500) -> all outputs at reset values immediately. After release, a write/read of 0xAAAA_5555_AAAA_5555 returns 0xAAAA first. clr_err clears the sticky flags.
